mem_ram_arb: RTL and testbench

MEM_RAM_ARB -- requirements
Module: mem_ram_arb

---
 rtl/mem_ram_arb.sv | 138 +++++++++++++
 tb/tb_mem_ram_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ram_arb.sv
// Two-master round-robin arbiter in front of a single-port-per-direction RAM,
// with a clear sweep that fills every word with CLR_VALUE.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | arbitrate M0/M1 requests, one grant per cycle
// S_CLEAR | write CLR_VALUE to one word per cycle, requests are held off
module mem_ram_arb #(
    parameter int                AWIDTH    = 8,
    parameter int                DWIDTH    = 32,
    parameter logic [DWIDTH-1:0] CLR_VALUE = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    output logic              BUSY,

    input  logic              M0_REQ,
    input  logic              M0_WE,
    input  logic [AWIDTH-1:0] M0_ADDR,
    input  logic [DWIDTH-1:0] M0_WDATA,
    output logic              M0_ACK,
    output logic              M0_RVALID,
    output logic [DWIDTH-1:0] M0_RDATA,

    input  logic              M1_REQ,
    input  logic              M1_WE,
    input  logic [AWIDTH-1:0] M1_ADDR,
    input  logic [DWIDTH-1:0] M1_WDATA,
    output logic              M1_ACK,
    output logic              M1_RVALID,
    output logic [DWIDTH-1:0] M1_RDATA,

    output logic              RAM_WEB,
    output logic [AWIDTH-1:0] RAM_WAD,
    output logic [DWIDTH-1:0] RAM_WDI,
    output logic [AWIDTH-1:0] RAM_RAD,
    input  logic [DWIDTH-1:0] RAM_RDO
);

    localparam int CWIDTH = AWIDTH - 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CWIDTH-1:0]   r_cnt;
    logic [CWIDTH-1:0]   w_cnt_nxt;
    logic                r_pri;
    logic                w_pri_nxt;
    logic                r_rv0;
    logic                r_rv1;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_last;

    assign w_last = (r_cnt == {CWIDTH{1'b1}});

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pri   <= 1'b0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pri   <= w_pri_nxt;
            r_rv0   <= w_gnt0 & ~M0_WE;
            r_rv1   <= w_gnt1 & ~M1_WE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pri_nxt   = r_pri;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        BUSY        = 1'b0;
        RAM_WEB     = 1'b0;
        RAM_WAD     = '0;
        RAM_RAD     = '0;
        RAM_WDI     = '0;

        case (r_state)
            S_IDLE: begin
                // RST gating keeps ACK and WEB low for the whole reset pulse
                if (!RST) begin
                    w_gnt0 = M0_REQ && (!M1_REQ || !r_pri);
                    w_gnt1 = M1_REQ && (!M0_REQ || r_pri);
                end
                if (w_gnt0) begin
                    RAM_WAD   = M0_ADDR;
                    RAM_RAD   = M0_ADDR;
                    RAM_WDI   = M0_WDATA;
                    RAM_WEB   = M0_WE;
                    w_pri_nxt = 1'b1;
                end else if (w_gnt1) begin
                    RAM_WAD   = M1_ADDR;
                    RAM_RAD   = M1_ADDR;
                    RAM_WDI   = M1_WDATA;
                    RAM_WEB   = M1_WE;
                    w_pri_nxt = 1'b0;
                end
                if (CLR && !RST) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                BUSY      = 1'b1;
                RAM_WEB   = 1'b1;
                RAM_WAD   = {r_cnt, 2'b00};
                RAM_WDI   = CLR_VALUE;
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign M0_ACK    = w_gnt0;
    assign M1_ACK    = w_gnt1;
    assign M0_RVALID = r_rv0;
    assign M1_RVALID = r_rv1;
    assign M0_RDATA  = RAM_RDO;
    assign M1_RDATA  = RAM_RDO;

endmodule

// File: tb/tb_mem_ram_arb.sv
// Bench for mem_ram_arb: behavioural RAM, a cycle model of arbitration and
// clear sweep, and per-master read-data scoreboards.
module tb_mem_ram_arb;

    localparam int          AW   = 8;
    localparam int          DW   = 32;
    localparam logic [31:0] CLRV = 32'hC1C1_C1C1;

    logic          CLK = 1'b0;
    logic          RST, CLR, BUSY;
    logic          M0_REQ, M0_WE, M0_ACK, M0_RVALID;
    logic [AW-1:0] M0_ADDR;
    logic [DW-1:0] M0_WDATA, M0_RDATA;
    logic          M1_REQ, M1_WE, M1_ACK, M1_RVALID;
    logic [AW-1:0] M1_ADDR;
    logic [DW-1:0] M1_WDATA, M1_RDATA;
    logic          RAM_WEB;
    logic [AW-1:0] RAM_WAD, RAM_RAD;
    logic [DW-1:0] RAM_WDI, RAM_RDO;

    mem_ram_arb #(.AWIDTH(AW), .DWIDTH(DW), .CLR_VALUE(CLRV)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .BUSY(BUSY),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_ACK(M0_ACK), .M0_RVALID(M0_RVALID), .M0_RDATA(M0_RDATA),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_ACK(M1_ACK), .M1_RVALID(M1_RVALID), .M1_RDATA(M1_RDATA),
        .RAM_WEB(RAM_WEB), .RAM_WAD(RAM_WAD), .RAM_WDI(RAM_WDI),
        .RAM_RAD(RAM_RAD), .RAM_RDO(RAM_RDO)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    // Attached RAM: synchronous write, registered read
    logic [DW-1:0] ram_mem [64];
    initial begin
        for (int i = 0; i < 64; i++) ram_mem[i] = init_val(i);
    end
    always @(posedge CLK) begin
        if (RAM_WEB) ram_mem[RAM_WAD[7:2]] <= RAM_WDI;
        RAM_RDO <= ram_mem[RAM_RAD[7:2]];
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          n_busy;
    logic [31:0] ref_mem [64];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic        m_busy, m_pri, m_g0, m_g1;
    logic [5:0]  m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [7:0] addr, input logic [31:0] data);
        if (m == 0) begin
            M0_REQ = req; M0_WE = we; M0_ADDR = addr; M0_WDATA = data;
        end else begin
            M1_REQ = req; M1_WE = we; M1_ADDR = addr; M1_WDATA = data;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
        CLR = 1'b0;
    endtask

    // One clock cycle: inputs already driven after a falling edge
    task automatic step();
        logic        g0, g1, ew, e0, e1;
        logic [7:0]  ea;
        logic [31:0] ed;
        #1;
        g0 = !m_busy && M0_REQ && (!M1_REQ || !m_pri);
        g1 = !m_busy && M1_REQ && (!M0_REQ || m_pri);
        chk("ack0", 32'(M0_ACK), 32'(g0));
        chk("ack1", 32'(M1_ACK), 32'(g1));
        chk("busy", 32'(BUSY), 32'(m_busy));
        if (m_busy) begin
            chk("clr_web", 32'(RAM_WEB), 32'd1);
            chk("clr_wad", 32'(RAM_WAD), 32'({m_cnt, 2'b00}));
            chk("clr_wdi", RAM_WDI, CLRV);
            ref_mem[m_cnt] = CLRV;
            n_busy++;
        end else begin
            ew = (g0 && M0_WE) || (g1 && M1_WE);
            chk("web", 32'(RAM_WEB), 32'(ew));
            if (g0 || g1) begin
                ea = g0 ? M0_ADDR : M1_ADDR;
                ed = g0 ? M0_WDATA : M1_WDATA;
                chk("rad", 32'(RAM_RAD), 32'(ea));
                chk("wad", 32'(RAM_WAD), 32'(ea));
                if (ew) begin
                    chk("wdi", RAM_WDI, ed);
                    ref_mem[ea[7:2]] = ed;
                end else if (g0) begin
                    q0.push_back(ref_mem[ea[7:2]]);
                end else begin
                    q1.push_back(ref_mem[ea[7:2]]);
                end
            end
        end
        if (g0) m_pri = 1'b1;
        if (g1) m_pri = 1'b0;
        if (!m_busy && CLR) begin
            m_busy = 1'b1;
            m_cnt  = 6'd0;
        end else if (m_busy) begin
            if (m_cnt == 6'd63) m_busy = 1'b0;
            m_cnt = m_cnt + 6'd1;
        end
        m_g0 = g0;
        m_g1 = g1;
        e0 = g0 && !M0_WE;
        e1 = g1 && !M1_WE;
        @(posedge CLK);
        #1;
        chk("rvalid0", 32'(M0_RVALID), 32'(e0));
        chk("rvalid1", 32'(M1_RVALID), 32'(e1));
        if (M0_RVALID) begin
            if (q0.size() == 0) chk("rv0_extra", 32'd1, 32'd0);
            else chk("rdata0", M0_RDATA, q0.pop_front());
        end
        if (M1_RVALID) begin
            if (q1.size() == 0) chk("rv1_extra", 32'd1, 32'd0);
            else chk("rdata1", M1_RDATA, q1.pop_front());
        end
        @(negedge CLK);
    endtask

    // Called right after a falling edge; requests stay driven to show ACK gating
    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_ack0", 32'(M0_ACK), 32'd0);
        chk("rst_ack1", 32'(M1_ACK), 32'd0);
        chk("rst_web", 32'(RAM_WEB), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        m_busy = 1'b0; m_cnt = 6'd0; m_pri = 1'b0;
        q0.delete(); q1.delete();
        @(posedge CLK);
        #1;
        chk("rst_rv0", 32'(M0_RVALID), 32'd0);
        chk("rst_rv1", 32'(M1_RVALID), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        idle_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic p0, p1;
        bit   done;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        RST = 1'b1;
        idle_all();
        drive(0, 1'b1, 1'b0, 8'h04, 32'h0);
        drive(1, 1'b1, 1'b1, 8'h08, 32'h0);
        do_reset();

        // Both masters read for 4 cycles from reset: M0,M1,M0,M1
        drive(0, 1'b1, 1'b0, 8'h04, 32'h0);
        drive(1, 1'b1, 1'b0, 8'h08, 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rr_order", 32'({m_g1, m_g0}), (c % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle_all();

        // Write by M0 then immediate read of the same word by M1
        drive(0, 1'b1, 1'b1, 8'h10, 32'hA5A5_A5A5);
        step();
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1, 1'b1, 1'b0, 8'h10, 32'h0);
        step();
        idle_all();
        step();

        // Random mixed traffic, requests held until acknowledged
        p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!p0) begin
                if ($urandom_range(0, 2) != 0) begin
                    drive(0, 1'b1, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 63)), $urandom);
                    p0 = 1'b1;
                end else drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
            end
            if (!p1) begin
                if ($urandom_range(0, 2) != 0) begin
                    drive(1, 1'b1, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 63)), $urandom);
                    p1 = 1'b1;
                end else drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
            end
            step();
            if (m_g0) p0 = 1'b0;
            if (m_g1) p1 = 1'b0;
        end
        idle_all();
        step();

        // Read acknowledged alongside CLR returns pre-clear data, then the sweep
        n_busy = 0;
        drive(0, 1'b1, 1'b0, 8'h40, 32'h0);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            CLR = (c == 10);
            step();
            if (m_g0) done = 1'b1;
        end
        CLR = 1'b0;
        chk("m0_wait_ack", 32'(done), 32'd1);
        chk("busy_cycles", 32'(n_busy), 32'd64);
        idle_all();
        step();

        // Reset in the middle of a sweep
        drive(1, 1'b1, 1'b1, 8'h4C, 32'h1919_1919); step();
        drive(1, 1'b1, 1'b1, 8'h50, 32'h2020_2020); step();
        drive(1, 1'b1, 1'b1, 8'h54, 32'h2121_2121); step();
        idle_all();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (m_busy && m_cnt == 6'd20) done = 1'b1;
            else step();
        end
        chk("sweep_word20", 32'(done), 32'd1);
        drive(0, 1'b1, 1'b0, 8'h4C, 32'h0);
        do_reset();
        for (int w = 19; w <= 21; w++) begin
            drive(0, 1'b1, 1'b0, 8'(w * 4), 32'h0);
            step();
        end
        chk("w19_clr", ref_mem[19], CLRV);
        chk("w21_old", ref_mem[21], 32'h2121_2121);
        idle_all();
        step();

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
